// File: rtl/uart_top.sv
// -----------------------------------------------------------------------------
// uart_top
//   8N1 UART echo block. Each byte received on rs232_rx is retransmitted
//   unchanged on rs232_tx. The design has three parts that share sys_clk:
//   a receiver, a one-byte holding buffer and a transmitter.
//
// Parameters
//   UART_BPS     serial bit rate
//   CLK_FREQ     sys_clk frequency in Hz
//   BAUD_CNT_MAX clocks per bit (CLK_FREQ / UART_BPS)
//
// Ports
//   sys_clk    in   system clock; all logic runs on the rising edge
//   sys_rst_n  in   asynchronous reset, active low
//   rs232_rx   in   serial input; idles high; asynchronous to sys_clk
//   rs232_tx   out  serial output; idles high; driven from a register
// -----------------------------------------------------------------------------
module uart_top #(
   parameter int UART_BPS     = 9600,
   parameter int CLK_FREQ     = 50_000_000,
   parameter int BAUD_CNT_MAX = CLK_FREQ / UART_BPS
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic rs232_rx,
   output logic rs232_tx
);

   localparam int              CW          = $clog2(BAUD_CNT_MAX);
   localparam logic [CW-1:0]   C_BAUD_LAST = CW'(BAUD_CNT_MAX - 1);
   localparam logic [CW-1:0]   C_BAUD_MID  = CW'(BAUD_CNT_MAX / 2 - 1);
   localparam logic [3:0]      C_IDX_START = 4'd0;
   localparam logic [3:0]      C_IDX_LAST  = 4'd8;  // last data bit
   localparam logic [3:0]      C_IDX_STOP  = 4'd9;

   // ---------------------------------------------------------------------------
   // Receiver input conditioning
   // ---------------------------------------------------------------------------
   // These flops reset to the idle level (1). A reset value of 0 would make
   // the first clock after reset look like a falling edge.
   logic r_rx_s1, r_rx_s2, r_rx_dly;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_rx_s1  <= 1'b1;
         r_rx_s2  <= 1'b1;
         r_rx_dly <= 1'b1;
      end else begin
         r_rx_s1  <= rs232_rx;
         r_rx_s2  <= r_rx_s1;
         r_rx_dly <= r_rx_s2;
      end
   end

   // ---------------------------------------------------------------------------
   // Receiver
   // ---------------------------------------------------------------------------
   logic          r_rx_busy;
   logic [CW-1:0] r_rx_cnt;
   logic [3:0]    r_rx_idx;
   logic [7:0]    r_rx_shift;
   logic [7:0]    r_rx_data;
   logic          r_rx_done;
   logic          w_rx_start;
   logic          w_rx_sample;

   assign w_rx_start  = !r_rx_busy && r_rx_dly && !r_rx_s2;
   assign w_rx_sample = r_rx_busy && (r_rx_cnt == C_BAUD_MID);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_rx_busy  <= 1'b0;
         r_rx_cnt   <= '0;
         r_rx_idx   <= '0;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_rx_done  <= 1'b0;
      end else begin
         r_rx_done <= 1'b0;
         if (w_rx_start) begin
            r_rx_busy <= 1'b1;
            r_rx_cnt  <= '0;
            r_rx_idx  <= '0;
         end else if (r_rx_busy) begin
            r_rx_cnt <= (r_rx_cnt == C_BAUD_LAST) ? '0 : r_rx_cnt + 1'b1;
            if (w_rx_sample) begin
               r_rx_idx <= r_rx_idx + 1'b1;
               if (r_rx_idx == C_IDX_START) begin
                  // Start bit high at mid-bit: only a glitch, go back to idle.
                  if (r_rx_s2) begin
                     r_rx_busy <= 1'b0;
                     r_rx_cnt  <= '0;
                     r_rx_idx  <= '0;
                  end
               end else if (r_rx_idx == C_IDX_STOP) begin
                  // Go idle at the mid-stop sample so that a start edge in the
                  // second half of the stop bit is still detected. A low stop
                  // bit is a framing error; the byte is dropped.
                  r_rx_busy <= 1'b0;
                  r_rx_cnt  <= '0;
                  r_rx_idx  <= '0;
                  if (r_rx_s2) begin
                     r_rx_data <= r_rx_shift;
                     r_rx_done <= 1'b1;
                  end
               end else begin
                  r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Holding buffer and transmitter handoff
   // ---------------------------------------------------------------------------
   // The transmitter can take a new byte when it is idle, and also on the last
   // clock of its stop bit (w_tx_end). That second case lets a queued byte
   // follow with no idle gap between frames.
   logic          r_tx_busy;
   logic [CW-1:0] r_tx_cnt;
   logic [3:0]    r_tx_idx;
   logic [7:0]    r_tx_shift;
   logic          r_tx_line;
   logic          r_hold_vld;
   logic [7:0]    r_hold_data;
   logic          w_tx_end;
   logic          w_tx_free;
   logic          w_tx_load;
   logic [7:0]    w_tx_byte;
   logic          w_hold_wr;

   assign w_tx_end  = r_tx_busy && (r_tx_cnt == C_BAUD_LAST) && (r_tx_idx == C_IDX_STOP);
   assign w_tx_free = !r_tx_busy || w_tx_end;
   assign w_tx_load = w_tx_free && (r_hold_vld || r_rx_done);
   // A byte that is already held is older than one arriving this clock.
   assign w_tx_byte = r_hold_vld ? r_hold_data : r_rx_data;
   // A new byte goes into the holding register unless it is sent to the
   // transmitter directly. If the register is already full, the new byte
   // overwrites the old one.
   assign w_hold_wr = r_rx_done && !(w_tx_load && !r_hold_vld);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_hold_vld  <= 1'b0;
         r_hold_data <= '0;
      end else if (w_hold_wr) begin
         r_hold_vld  <= 1'b1;
         r_hold_data <= r_rx_data;
      end else if (w_tx_load) begin
         r_hold_vld  <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Transmitter
   // ---------------------------------------------------------------------------
   // r_tx_line changes only when the baud counter wraps or a byte is loaded,
   // so the output can change only at bit boundaries.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_tx_busy  <= 1'b0;
         r_tx_cnt   <= '0;
         r_tx_idx   <= '0;
         r_tx_shift <= '0;
         r_tx_line  <= 1'b1;
      end else if (w_tx_load) begin
         r_tx_busy  <= 1'b1;
         r_tx_cnt   <= '0;
         r_tx_idx   <= '0;
         r_tx_shift <= w_tx_byte;
         r_tx_line  <= 1'b0;
      end else if (w_tx_end) begin
         r_tx_busy  <= 1'b0;
         r_tx_cnt   <= '0;
         r_tx_idx   <= '0;
         r_tx_line  <= 1'b1;
      end else if (r_tx_busy) begin
         if (r_tx_cnt == C_BAUD_LAST) begin
            r_tx_cnt <= '0;
            r_tx_idx <= r_tx_idx + 1'b1;
            if (r_tx_idx == C_IDX_LAST) begin
               r_tx_line <= 1'b1;
            end else begin
               r_tx_line  <= r_tx_shift[0];
               r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
         end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
         end
      end
   end

   assign rs232_tx = r_tx_line;

endmodule

// File: tb/tb_uart_top.sv
// -----------------------------------------------------------------------------
// tb_uart_top
//   Directed bench for uart_top. It is scaled to 16 clocks per bit
//   (CLK_FREQ=160, UART_BPS=10). A monitor decodes every frame on rs232_tx
//   into queues. Each test task drives rs232_rx and compares the decoded
//   frames against hand-computed values.
//   Echo latency (LAT): count from the negedge that drives the input start
//   bit to the negedge where the output start bit is first seen.
//     - 2 synchronizer clocks
//     - 1 clock for start detect
//     - 9 full bits plus 8 clocks to the mid-stop sample
//     - 1 clock to load the transmitter
//     Total: 3 + 144 + 8 + 1 = 156 clocks.
// -----------------------------------------------------------------------------
module tb_uart_top;

   localparam int UART_BPS = 10;
   localparam int CLK_FREQ = 160;
   localparam int M        = 16;
   localparam int FRAME    = 160;
   localparam int LAT      = 156;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b1;
   logic rs232_rx  = 1'b1;
   logic rs232_tx;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [7:0] q_byte [$];
   int         q_start[$];
   bit         q_ok   [$];

   uart_top #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .rs232_rx  (rs232_rx),
      .rs232_tx  (rs232_tx)
   );

   always #10 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // Frame monitor
   // It samples each bit at mid-bit. It also clears the ok flag if the line
   // changes anywhere inside a bit.
   bit         m_busy  = 1'b0;
   int         m_off   = 0;
   int         m_start = 0;
   logic       m_cur   = 1'b1;
   bit         m_stab  = 1'b1;
   logic [9:0] m_bits  = '0;

   initial begin
      forever begin
         @(negedge sys_clk);
         if (!sys_rst_n) begin
            m_busy = 1'b0;
         end else begin
            if (!m_busy) begin
               if (rs232_tx === 1'b0) begin
                  m_busy  = 1'b1;
                  m_off   = 0;
                  m_start = cyc;
                  m_stab  = 1'b1;
               end
            end else begin
               m_off++;
            end
            if (m_busy) begin
               if (m_off % M == 0) m_cur = rs232_tx;
               else if (rs232_tx !== m_cur) m_stab = 1'b0;
               if (m_off % M == M/2) m_bits[m_off/M] = rs232_tx;
               if (m_off == FRAME-1) begin
                  q_byte.push_back(m_bits[8:1]);
                  q_start.push_back(m_start);
                  q_ok.push_back(m_stab && (m_bits[0] === 1'b0) && (m_bits[9] === 1'b1));
                  m_busy = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_q();
      q_byte.delete();
      q_start.delete();
      q_ok.delete();
   endtask

   // Drives one frame. Call it on a negedge; it returns on a negedge.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rs232_rx = f[i];
         repeat ((i == 9) ? stop_len : M) @(negedge sys_clk);
      end
   endtask

   task automatic wait_frames(input int n, input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         if (q_byte.size() >= n) got = 1'b1;
         else @(negedge sys_clk);
      end
      if (q_byte.size() >= n) got = 1'b1;
   endtask

   task automatic test_reset();
      #1 sys_rst_n = 1'b0;
      #5;
      n_cmp++;
      if (rs232_tx !== 1'b1) begin
         n_err++; $display("FAIL reset_during: tx=%b want 1", rs232_tx);
      end
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      clear_q();
      repeat (50) @(negedge sys_clk);
      n_cmp++;
      if (rs232_tx !== 1'b1) begin
         n_err++; $display("FAIL reset_after: tx=%b want 1", rs232_tx);
      end
      n_cmp++;
      if (q_byte.size() != 0) begin
         n_err++; $display("FAIL reset_idle: frames=%0d want 0", q_byte.size());
      end
   endtask

   task automatic test_single_zero();
      int s; bit got;
      clear_q();
      s = cyc;
      send_frame(8'h00, 1'b1, M);
      wait_frames(1, 400, got);
      n_cmp++;
      if (!got) begin
         n_err++; $display("FAIL single_timeout: frames=%0d want 1", q_byte.size());
      end else begin
         n_cmp++;
         if (q_byte[0] !== 8'h00) begin
            n_err++; $display("FAIL single_data: got %h want 00", q_byte[0]);
         end
         n_cmp++;
         if (q_ok[0] !== 1'b1) begin
            n_err++; $display("FAIL single_frame: ok=%b want 1", q_ok[0]);
         end
         n_cmp++;
         if (q_start[0] - s != LAT) begin
            n_err++; $display("FAIL single_latency: got %0d want %0d", q_start[0] - s, LAT);
         end
      end
      repeat (10) @(negedge sys_clk);
   endtask

   task automatic test_back_to_back();
      int s; bit got;
      clear_q();
      s = cyc;
      for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1, M);
      wait_frames(8, 600, got);
      repeat (200) @(negedge sys_clk);
      n_cmp++;
      if (!got || q_byte.size() != 8) begin
         n_err++; $display("FAIL b2b_count: frames=%0d want 8", q_byte.size());
      end else begin
         n_cmp++;
         if (q_start[0] - s != LAT) begin
            n_err++; $display("FAIL b2b_latency: got %0d want %0d", q_start[0] - s, LAT);
         end
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (q_byte[i] !== 8'(i) || q_ok[i] !== 1'b1) begin
               n_err++; $display("FAIL b2b_data[%0d]: got %h ok=%b want %h ok=1", i, q_byte[i], q_ok[i], 8'(i));
            end
            if (i > 0) begin
               n_cmp++;
               if (q_start[i] - q_start[i-1] != FRAME) begin
                  n_err++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, q_start[i] - q_start[i-1], FRAME);
               end
            end
         end
      end
   endtask

   task automatic test_a5();
      bit got;
      clear_q();
      send_frame(8'hA5, 1'b1, M);
      wait_frames(1, 400, got);
      n_cmp++;
      // The time order of the data bits is 1,0,1,0,0,1,0,1 (first bit first),
      // which reads back as 0xA5 LSB first.
      if (!got || q_byte[0] !== 8'hA5 || q_ok[0] !== 1'b1) begin
         n_err++; $display("FAIL a5_data: got %h frames=%0d want a5", got ? q_byte[0] : 8'h00, q_byte.size());
      end
      repeat (10) @(negedge sys_clk);
   endtask

   task automatic test_false_start();
      int s; bit got;
      clear_q();
      rs232_rx = 1'b0;
      repeat (3) @(negedge sys_clk);
      rs232_rx = 1'b1;
      repeat (M) @(negedge sys_clk);
      s = cyc;
      send_frame(8'h3C, 1'b1, M);
      wait_frames(1, 400, got);
      repeat (200) @(negedge sys_clk);
      n_cmp++;
      if (q_byte.size() != 1) begin
         n_err++; $display("FAIL false_count: frames=%0d want 1", q_byte.size());
      end else begin
         n_cmp++;
         if (q_byte[0] !== 8'h3C || q_ok[0] !== 1'b1) begin
            n_err++; $display("FAIL false_data: got %h want 3c", q_byte[0]);
         end
         n_cmp++;
         if (q_start[0] - s != LAT) begin
            n_err++; $display("FAIL false_latency: got %0d want %0d", q_start[0] - s, LAT);
         end
      end
   endtask

   task automatic test_framing();
      bit got;
      clear_q();
      send_frame(8'h55, 1'b0, M);
      rs232_rx = 1'b1;
      repeat (300) @(negedge sys_clk);
      n_cmp++;
      if (q_byte.size() != 0 || rs232_tx !== 1'b1) begin
         n_err++; $display("FAIL framing_drop: frames=%0d tx=%b want 0 frames tx=1", q_byte.size(), rs232_tx);
      end
      send_frame(8'h81, 1'b1, M);
      wait_frames(1, 400, got);
      n_cmp++;
      if (!got || q_byte[0] !== 8'h81) begin
         n_err++; $display("FAIL framing_recover: got %h frames=%0d want 81", got ? q_byte[0] : 8'h00, q_byte.size());
      end
      repeat (10) @(negedge sys_clk);
   endtask

   // The input stop bits are short, so frames arrive faster than they can be
   // sent. The holding register must absorb the overlap without losing a byte.
   task automatic test_hold();
      int s; bit got;
      clear_q();
      s = cyc;
      for (int i = 0; i < 4; i++) send_frame(8'(8'h11 << i), 1'b1, M/2 + 4);
      wait_frames(4, 800, got);
      repeat (200) @(negedge sys_clk);
      n_cmp++;
      if (!got || q_byte.size() != 4) begin
         n_err++; $display("FAIL hold_count: frames=%0d want 4", q_byte.size());
      end else begin
         n_cmp++;
         if (q_start[0] - s != LAT) begin
            n_err++; $display("FAIL hold_latency: got %0d want %0d", q_start[0] - s, LAT);
         end
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (q_byte[i] !== 8'(8'h11 << i) || q_ok[i] !== 1'b1) begin
               n_err++; $display("FAIL hold_data[%0d]: got %h want %h", i, q_byte[i], 8'(8'h11 << i));
            end
            if (i > 0) begin
               n_cmp++;
               if (q_start[i] - q_start[i-1] != FRAME) begin
                  n_err++; $display("FAIL hold_gap[%0d]: got %0d want %0d", i, q_start[i] - q_start[i-1], FRAME);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid_tx();
      int s; bit got;
      clear_q();
      send_frame(8'h00, 1'b1, M);
      // The output start bit began 4 clocks before the send ended. Another
      // 36 clocks puts the output 40 clocks into the frame, inside data bit 1.
      repeat (36) @(negedge sys_clk);
      n_cmp++;
      if (rs232_tx !== 1'b0) begin
         n_err++; $display("FAIL midtx_active: tx=%b want 0", rs232_tx);
      end
      sys_rst_n = 1'b0;
      #1;
      n_cmp++;
      if (rs232_tx !== 1'b1) begin
         n_err++; $display("FAIL midtx_reset: tx=%b want 1", rs232_tx);
      end
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      clear_q();
      repeat (200) @(negedge sys_clk);
      n_cmp++;
      if (q_byte.size() != 0 || rs232_tx !== 1'b1) begin
         n_err++; $display("FAIL midtx_idle: frames=%0d tx=%b want 0 frames tx=1", q_byte.size(), rs232_tx);
      end
      s = cyc;
      send_frame(8'h5A, 1'b1, M);
      wait_frames(1, 400, got);
      n_cmp++;
      if (!got || q_byte[0] !== 8'h5A || q_start[0] - s != LAT) begin
         n_err++; $display("FAIL midtx_echo: got %h frames=%0d want 5a at latency %0d", got ? q_byte[0] : 8'h00, q_byte.size(), LAT);
      end
   endtask

   initial begin
      test_reset();
      test_single_zero();
      test_back_to_back();
      test_a5();
      test_false_start();
      test_framing();
      test_hold();
      test_reset_mid_tx();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_top.md
# uart_top

Full-duplex UART echo block: receives 8N1 serial bytes on `rs232_rx` and retransmits each received byte unchanged on `rs232_tx`. It contains a receiver, a one-byte holding buffer and a transmitter sharing one clock. It sits at the board pins as the serial-port front end and loopback test block.

## Interface
- `UART_BPS`, 9600: serial bit rate.
- `CLK_FREQ`, 50_000_000: `sys_clk` frequency in Hz.
- `BAUD_CNT_MAX`, derived as `CLK_FREQ/UART_BPS` (5208): clocks per bit.
- `sys_clk`  input  1  system clock, 50 MHz; all logic on the rising edge.
- `sys_rst_n`  input  1  reset, asynchronous and active-low.
- `rs232_rx`  input  1  serial input, idle high, asynchronous to `sys_clk`.
- `rs232_tx`  output  1  serial output, idle high, driven from a register.

## Operation
- Frame format is 8N1: start bit (0), data bits 0–7 LSB first, one stop bit (1). Each bit lasts `BAUD_CNT_MAX` clocks.
- Receiver input conditioning:
  - `rs232_rx` passes through a 2-flop synchronizer and a third delay flop.
  - A start is detected when the receiver is idle, the delayed copy is 1 and the synchronized copy is 0 (falling edge).
- Receiver counting:
  - On start detect, `rx_busy` sets and the baud counter runs from 0 to `BAUD_CNT_MAX-1`, wrapping.
  - A sample is taken when the counter equals `BAUD_CNT_MAX/2-1` (2603), i.e. mid-bit.
  - The bit index runs 0..9 and advances at each sample.
- Receiver sampling:
  - Index 0 is the start bit. If it samples 1, this is a false start: return to idle and emit no byte.
  - Indices 1–8 are data, shifted in LSB first.
  - Index 9 is the stop bit. If it samples 1, the byte is latched and `rx_done` pulses for one clock. If it samples 0 (framing error), the byte is discarded.
  - In both stop-bit cases the receiver returns to idle at that sample, so the next start edge is accepted during the remainder of the stop bit.
- Holding buffer:
  - `rx_done` while the transmitter is idle starts transmission on the next clock.
  - `rx_done` while the transmitter is busy loads a one-byte holding register.
  - The held byte starts transmission immediately after the current stop bit ends.
  - A second `rx_done` while the holding register is already full overwrites it (newest wins).
- Transmitter:
  - Loads the byte, then drives start, data[0..7], stop, each for exactly `BAUD_CNT_MAX` clocks. Its baud counter is independent of the receiver's.
  - `tx_busy` clears on the last clock of the stop bit, so a pending byte's start bit follows with no idle gap.
- Reset: all counters 0, receiver and transmitter idle, holding register empty, data registers 0x00, `rs232_tx` = 1. Reset mid-frame aborts both directions immediately.

## Timing
- Receive latency: the mid-stop sample occurs 2 (synchronizer) + 9×5208 + 2603 clocks after the input falling edge. `rx_done` is registered one clock after that sample.
- Transmit start bit appears on `rs232_tx` one clock after `rx_done`. Total echo latency is about 49,480 clocks (~989.6 µs) from the input start edge to the output start edge.
- Output frame length is exactly 10×5208 = 52,080 clocks.
- Back-to-back input frames (period 52,080 clocks) must be echoed back-to-back with no byte loss.
- `rs232_tx` is glitch-free and changes only at bit boundaries.

## Test plan
- Reset: hold `sys_rst_n`=0 for 20 ns, with `rs232_rx`=1 -> `rs232_tx`=1 during and after reset, no activity.
- Single byte 0x00 sent at 9600 baud starting at 200 ns -> `rs232_tx` emits start, eight 0s, stop. Output start edge ≈989.6 µs after the input start edge. Each bit is 104,160 ns wide.
- Eight back-to-back frames 0x00..0x07 (no idle between stop and next start) -> `rs232_tx` emits 0x00..0x07 in order, contiguous, with no missing or duplicated byte.
- Byte 0xA5 -> output data bits, in time order, are 1,0,1,0,0,1,0,1 (LSB first).
- False start: 1 µs low pulse on `rs232_rx` -> no output frame, and the receiver accepts a valid 0x3C sent immediately afterward.
- Framing error: frame with stop bit = 0 -> no output byte. Asserting reset mid-transmit -> `rs232_tx` returns to 1 at once, and the next byte is echoed normally.
